// File: rtl/mem_bundle_pkg.sv
// Constants shared by the MEM stage and the data RAM responder: bus widths,
// responder FSM state encodings and the load/store funct3 encodings.
package mem_bundle_pkg;

  localparam int AddrWidth = 32;
  localparam int DataWidth = 32;
  localparam int WordSize  = 4;
  localparam int ByteBits  = 8;

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] READ_WAIT = 1'b1;

  // funct3 encodings as seen by the MEM stage
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/ram_byte_bank.sv
// Word-organised storage with per-byte write enables and a registered read
// port; rd_zero forces the returned word to zero for out-of-range reads.
module ram_byte_bank
  import mem_bundle_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int WordSize   = 4,
  parameter int DepthWords = 1024,
  parameter int AddrBits   = $clog2(DepthWords)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WordSize-1:0]  wr_strobe,
  input  logic [AddrBits-1:0]  wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic                 rd_en,
  input  logic                 rd_zero,
  input  logic [AddrBits-1:0]  rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] mem [DepthWords];
  logic [DataWidth-1:0] rd_data_d;
  logic [DataWidth-1:0] rd_data_q;

  // Byte-lane writes; contents deliberately survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < WordSize; i++) begin
      if (wr_en && wr_strobe[i]) begin
        mem[wr_addr][i*ByteBits +: ByteBits] <= wr_data[i*ByteBits +: ByteBits];
      end
    end
  end

  // Next read word: hold unless a read completes this cycle
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (rd_zero) begin
        rd_data_d = {DataWidth{1'b0}};
      end else begin
        rd_data_d = mem[rd_addr];
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= {DataWidth{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/data_ram_responder.sv
// Data RAM responder for the MEM stage: valid/ready request port, byte-strobed
// stores, loads returned after ReadLatency cycles, one request in flight.
module data_ram_responder
  import mem_bundle_pkg::*;
#(
  parameter int AddrWidth   = mem_bundle_pkg::AddrWidth,
  parameter int DataWidth   = mem_bundle_pkg::DataWidth,
  parameter int WordSize    = mem_bundle_pkg::WordSize,
  parameter int DepthWords  = 1024,
  parameter int ReadLatency = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AddrWidth-1:0] address,
  input  logic [DataWidth-1:0] write_data,
  input  logic                 write_enable,
  input  logic [WordSize-1:0]  write_strobe,
  output logic [DataWidth-1:0] read_data,
  output logic                 read_valid,
  output logic                 write_done,
  output logic                 addr_error
);

  localparam int RamAw = $clog2(DepthWords);
  localparam int IdxW  = AddrWidth - 2;
  localparam logic [IdxW-1:0] DepthLim = IdxW'(DepthWords);
  localparam logic [2:0]      CntLoad  = 3'(ReadLatency - 1);

  logic [0:0]      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            read_valid_q, read_valid_d;
  logic            write_done_q, write_done_d;
  logic            addr_error_q, addr_error_d;

  logic [IdxW-1:0] req_idx;
  logic            req_in_range;
  logic            pend_in_range;
  logic            accept;
  logic            ram_we, ram_re, ram_rzero;
  logic [RamAw-1:0] ram_raddr;
  logic            addr_lsb_unused;

  assign req_idx         = address[AddrWidth-1:2];
  assign addr_lsb_unused = ^address[1:0];
  assign req_in_range    = (req_idx < DepthLim);
  assign pend_in_range   = (idx_q < DepthLim);
  assign req_ready       = (state_q == IDLE);
  assign accept          = req_valid & req_ready;

  // FSM, latency counter and response pulse generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    read_valid_d = 1'b0;
    write_done_d = 1'b0;
    addr_error_d = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_rzero    = 1'b0;
    ram_raddr    = idx_q[RamAw-1:0];
    case (state_q)
      IDLE: begin
        if (accept && write_enable) begin
          ram_we       = req_in_range;
          write_done_d = 1'b1;
          addr_error_d = ~req_in_range;
        end else if (accept && (ReadLatency == 1)) begin
          // single-cycle latency: read straight from the request address
          ram_re       = 1'b1;
          ram_rzero    = ~req_in_range;
          ram_raddr    = req_idx[RamAw-1:0];
          read_valid_d = 1'b1;
          addr_error_d = ~req_in_range;
        end else if (accept) begin
          state_d = READ_WAIT;
          cnt_d   = CntLoad;
          idx_d   = req_idx;
        end else begin
          state_d = IDLE;
        end
      end
      READ_WAIT: begin
        // last wait cycle: read so the response lands as the FSM reopens
        if (cnt_q <= 3'd1) begin
          ram_re       = 1'b1;
          ram_rzero    = ~pend_in_range;
          read_valid_d = 1'b1;
          addr_error_d = ~pend_in_range;
          cnt_d        = 3'd0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      idx_q        <= {IdxW{1'b0}};
      read_valid_q <= 1'b0;
      write_done_q <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      read_valid_q <= read_valid_d;
      write_done_q <= write_done_d;
      addr_error_q <= addr_error_d;
    end
  end

  ram_byte_bank #(
    .DataWidth (DataWidth),
    .WordSize  (WordSize),
    .DepthWords(DepthWords),
    .AddrBits  (RamAw)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (ram_we),
    .wr_strobe(write_strobe),
    .wr_addr  (req_idx[RamAw-1:0]),
    .wr_data  (write_data),
    .rd_en    (ram_re),
    .rd_zero  (ram_rzero),
    .rd_addr  (ram_raddr),
    .rd_data  (read_data)
  );

  assign read_valid = read_valid_q;
  assign write_done = write_done_q;
  assign addr_error = addr_error_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed self-checking bench for data_ram_responder (DepthWords=1024, ReadLatency=2).
module tb_data_ram_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic [3:0]  write_strobe;
  logic [31:0] read_data;
  logic        read_valid;
  logic        write_done;
  logic        addr_error;

  int n_cmp;
  int n_bad;

  data_ram_responder #(
    .DepthWords (1024),
    .ReadLatency(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .address     (address),
    .write_data  (write_data),
    .write_enable(write_enable),
    .write_strobe(write_strobe),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .write_done  (write_done),
    .addr_error  (addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Store request; returns at the negedge of the cycle after acceptance
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic wd, output logic ae);
    req_valid = 1'b1; write_enable = 1'b1; address = a; write_data = d; write_strobe = s;
    @(negedge clk);
    req_valid = 1'b0; write_enable = 1'b0;
    wd = write_done;
    ae = addr_error;
  endtask

  // Load request; lat = cycles from the accept cycle to read_valid (99 on timeout)
  task automatic do_load(input logic [31:0] a, output logic [31:0] d, output logic ae,
                         output int lat);
    req_valid = 1'b1; write_enable = 1'b0; address = a; write_strobe = 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 99; d = 32'h0; ae = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (read_valid === 1'b1) begin
        lat = i; d = read_data; ae = addr_error;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL reset_read_data: got %h want %h", read_data, 32'h0); end
    n_cmp++; if (read_valid !== 1'b0) begin n_bad++; $display("FAIL reset_read_valid: got %b want 0", read_valid); end
    n_cmp++; if (write_done !== 1'b0) begin n_bad++; $display("FAIL reset_write_done: got %b want 0", write_done); end
    n_cmp++; if (addr_error !== 1'b0) begin n_bad++; $display("FAIL reset_addr_error: got %b want 0", addr_error); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_store_load();
    logic wd, ae; logic [31:0] d; int lat;
    do_store(32'h0000_0000, 32'h5A5A_5A5A, 4'hF, wd, ae);
    do_store(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, wd, ae);
    n_cmp++; if (wd !== 1'b1 || ae !== 1'b0) begin n_bad++; $display("FAIL sw_write_done: got wd=%b ae=%b want wd=1 ae=0", wd, ae); end
    n_cmp++; if (write_done !== 1'b0) begin end
    @(negedge clk);
    n_cmp++; if (write_done !== 1'b0) begin n_bad++; $display("FAIL sw_done_pulse: got %b want 0", write_done); end
    do_load(32'h0000_0010, d, ae, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
    n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_data: got %h want %h", d, 32'hDEAD_BEEF); end
    @(negedge clk);
    n_cmp++; if (read_valid !== 1'b0) begin n_bad++; $display("FAIL lw_valid_pulse: got %b want 0", read_valid); end
    do_store(32'h0000_0040, 32'h0BAD_F00D, 4'hF, wd, ae);
    n_cmp++; if (read_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL read_data_hold: got %h want %h", read_data, 32'hDEAD_BEEF); end
  endtask

  task automatic test_byte_lanes();
    logic wd, ae; logic [31:0] d; int lat;
    do_store(32'h0000_0011, 32'h0000_AB00, 4'b0010, wd, ae);
    do_load(32'h0000_0010, d, ae, lat);
    n_cmp++; if (d !== 32'hDEAD_ABEF) begin n_bad++; $display("FAIL sb_merge: got %h want %h", d, 32'hDEAD_ABEF); end
    do_store(32'h0000_0012, 32'h1234_0000, 4'b1100, wd, ae);
    do_load(32'h0000_0010, d, ae, lat);
    n_cmp++; if (d !== 32'h1234_ABEF) begin n_bad++; $display("FAIL sh_merge: got %h want %h", d, 32'h1234_ABEF); end
    do_store(32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, wd, ae);
    n_cmp++; if (wd !== 1'b1) begin n_bad++; $display("FAIL zero_strobe_done: got %b want 1", wd); end
    do_load(32'h0000_0010, d, ae, lat);
    n_cmp++; if (d !== 32'h1234_ABEF) begin n_bad++; $display("FAIL zero_strobe_data: got %h want %h", d, 32'h1234_ABEF); end
  endtask

  task automatic test_back_to_back();
    logic wd, ae; logic [31:0] d; int lat;
    do_store(32'h0000_0020, 32'hCAFE_F00D, 4'hF, wd, ae);
    do_load(32'h0000_0020, d, ae, lat);
    n_cmp++; if (d !== 32'hCAFE_F00D || lat !== 2) begin n_bad++; $display("FAIL b2b_store_load: got %h lat %0d want %h lat 2", d, lat, 32'hCAFE_F00D); end
  endtask

  task automatic test_stall();
    logic [31:0] d; logic ae; int lat;
    req_valid = 1'b1; write_enable = 1'b0; address = 32'h0000_0010; write_strobe = 4'h0;
    @(negedge clk);
    write_enable = 1'b1; write_data = 32'h0000_0000; write_strobe = 4'hF;
    n_cmp++; if (req_ready !== 1'b0 || write_done !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got ready=%b done=%b want 0/0", req_ready, write_done); end
    @(negedge clk);
    n_cmp++; if (read_valid !== 1'b1 || req_ready !== 1'b1) begin n_bad++; $display("FAIL stall_response: got rv=%b ready=%b want 1/1", read_valid, req_ready); end
    n_cmp++; if (read_data !== 32'h1234_ABEF) begin n_bad++; $display("FAIL stall_mem_unchanged: got %h want %h", read_data, 32'h1234_ABEF); end
    @(negedge clk);
    req_valid = 1'b0; write_enable = 1'b0;
    n_cmp++; if (write_done !== 1'b1) begin n_bad++; $display("FAIL stall_store_taken: got %b want 1", write_done); end
    do_load(32'h0000_0010, d, ae, lat);
    n_cmp++; if (d !== 32'h0000_0000) begin n_bad++; $display("FAIL stall_store_data: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_addr_error();
    logic wd, ae; logic [31:0] d; int lat;
    do_load(32'h0000_0020, d, ae, lat);
    do_load(32'h0000_1000, d, ae, lat);
    n_cmp++; if (d !== 32'h0 || ae !== 1'b1) begin n_bad++; $display("FAIL oob_load: got %h ae=%b want 0 ae=1", d, ae); end
    do_store(32'h0000_1000, 32'hFFFF_FFFF, 4'hF, wd, ae);
    n_cmp++; if (wd !== 1'b1 || ae !== 1'b1) begin n_bad++; $display("FAIL oob_store: got wd=%b ae=%b want 1/1", wd, ae); end
    do_load(32'h0000_0000, d, ae, lat);
    n_cmp++; if (d !== 32'h5A5A_5A5A || ae !== 1'b0) begin n_bad++; $display("FAIL oob_word0: got %h ae=%b want %h ae=0", d, ae, 32'h5A5A_5A5A); end
  endtask

  task automatic test_reset_drop();
    logic wd, ae; logic [31:0] d; int lat; int seen;
    do_store(32'h0000_0010, 32'h1234_ABEF, 4'hF, wd, ae);
    req_valid = 1'b1; write_enable = 1'b0; address = 32'h0000_0010;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    seen = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (read_valid === 1'b1) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_drop_valid: got %0d pulses want 0", seen); end
    n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL rst_drop_data: got %h want 0", read_data); end
    do_load(32'h0000_0010, d, ae, lat);
    n_cmp++; if (d !== 32'h1234_ABEF || lat !== 2) begin n_bad++; $display("FAIL rst_mem_kept: got %h lat %0d want %h lat 2", d, lat, 32'h1234_ABEF); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; req_valid = 1'b0; address = 32'h0; write_data = 32'h0;
    write_enable = 1'b0; write_strobe = 4'h0;
    @(negedge clk);
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_back_to_back();
    test_stall();
    test_addr_error();
    test_reset_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
